adpcm_sched: RTL

- Time-shares one ADPCM codec core between an encode requester (PCM in, nibble out) and a decode requester (nibble in, PCM out).
- Arbitrates the two requesters round-robin and captures the operand.
- Drives the core's sel_rx/data/toggle-req interface with the required setup time, waits for completion on the core's ack, and returns the result with a one-cycle valid pulse.
- Watchdog flags a core that never starts or never finishes.

---
 rtl/adpcm_sched.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/adpcm_sched.sv
// Time-shares one ADPCM codec core between an encode and a decode requester:
// round-robin grant, operand setup, toggle handshake, result return and watchdog.
module adpcm_sched #(
  parameter int SETUP_CYC = 2,
  parameter int TIMEOUT   = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_enc_valid,
  input  logic [15:0] i_enc_pcm,
  output logic        o_enc_ready,
  output logic        o_enc_out_valid,
  output logic [3:0]  o_enc_adpcm,
  input  logic        i_dec_valid,
  input  logic [3:0]  i_dec_adpcm,
  output logic        o_dec_ready,
  output logic        o_dec_out_valid,
  output logic [15:0] o_dec_pcm,
  output logic        o_core_enable,
  output logic        o_core_req,
  output logic        o_core_sel_rx,
  output logic [15:0] o_core_rx_pcm,
  output logic [3:0]  o_core_rx_adpcm,
  input  logic        i_core_ack,
  input  logic [15:0] i_core_tx_pcm,
  input  logic [3:0]  i_core_tx_adpcm,
  output logic        o_busy,
  output logic        o_err
);

  // The core needs at least two cycles of stable operand before the request toggle.
  localparam int SETUP_EFF = (SETUP_CYC < 2) ? 2 : SETUP_CYC;
  localparam int CNT_MAX   = (TIMEOUT > SETUP_EFF - 1) ? TIMEOUT : SETUP_EFF - 1;
  localparam int CW        = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETUP_LOAD   = CW'(SETUP_EFF - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_BUSY,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  typedef enum logic {
    GRANT_ENC,
    GRANT_DEC
  } grant_t;

  state_t        r_state, w_stateNext;
  grant_t        r_lastGrant, w_lastGrantNext;
  logic [CW-1:0] r_cnt, w_cntNext;
  logic          r_coreReq, w_coreReqNext;
  logic          r_coreSelRx, w_coreSelRxNext;
  logic [15:0]   r_coreRxPcm, w_coreRxPcmNext;
  logic [3:0]    r_coreRxAdpcm, w_coreRxAdpcmNext;
  logic [3:0]    r_encAdpcm, w_encAdpcmNext;
  logic [15:0]   r_decPcm, w_decPcmNext;
  logic          r_encOutValid, w_encOutValidNext;
  logic          r_decOutValid, w_decOutValidNext;
  logic          r_err, w_errNext;

  logic w_encReady;
  logic w_decReady;
  logic w_encGrant;
  logic w_decGrant;

  // A requester only loses a tie when it was the one served last.
  assign w_encReady = i_enable && !i_rst && (r_state == S_IDLE) &&
                      !(i_dec_valid && (r_lastGrant == GRANT_ENC));
  assign w_decReady = i_enable && !i_rst && (r_state == S_IDLE) &&
                      !(i_enc_valid && (r_lastGrant == GRANT_DEC));
  assign w_encGrant = i_enc_valid && w_encReady;
  assign w_decGrant = i_dec_valid && w_decReady && !w_encGrant;

  always_comb begin
    w_stateNext        = r_state;
    w_lastGrantNext    = r_lastGrant;
    w_cntNext          = r_cnt;
    w_coreReqNext      = r_coreReq;
    w_coreSelRxNext    = r_coreSelRx;
    w_coreRxPcmNext    = r_coreRxPcm;
    w_coreRxAdpcmNext  = r_coreRxAdpcm;
    w_encAdpcmNext     = r_encAdpcm;
    w_decPcmNext       = r_decPcm;
    w_encOutValidNext  = 1'b0;
    w_decOutValidNext  = 1'b0;
    w_errNext          = r_err;

    case (r_state)
      S_IDLE: begin
        if (w_encGrant) begin
          w_stateNext     = S_SETUP;
          w_coreRxPcmNext = i_enc_pcm;
          w_coreSelRxNext = 1'b0;
          w_lastGrantNext = GRANT_ENC;
          w_cntNext       = SETUP_LOAD;
        end else if (w_decGrant) begin
          w_stateNext       = S_SETUP;
          w_coreRxAdpcmNext = i_dec_adpcm;
          w_coreSelRxNext   = 1'b1;
          w_lastGrantNext   = GRANT_DEC;
          w_cntNext         = SETUP_LOAD;
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_coreReqNext = ~r_coreReq;
          w_cntNext     = TIMEOUT_LOAD;
          w_stateNext   = S_BUSY;
        end else begin
          w_cntNext = r_cnt - CW'(1);
        end
      end
      S_BUSY: begin
        // The core drops ack once it has picked up the toggle.
        if (!i_core_ack) begin
          w_stateNext = S_WAIT_DONE;
          w_cntNext   = TIMEOUT_LOAD;
        end else if (r_cnt == '0) begin
          w_errNext   = 1'b1;
          w_stateNext = S_DONE;
        end else begin
          w_cntNext = r_cnt - CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (i_core_ack) begin
          if (r_coreSelRx) begin
            w_decPcmNext      = i_core_tx_pcm;
            w_decOutValidNext = 1'b1;
          end else begin
            w_encAdpcmNext    = i_core_tx_adpcm;
            w_encOutValidNext = 1'b1;
          end
          w_stateNext = S_DONE;
        end else if (r_cnt == '0) begin
          w_errNext   = 1'b1;
          w_stateNext = S_DONE;
        end else begin
          w_cntNext = r_cnt - CW'(1);
        end
      end
      S_DONE: w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase

    if (!i_enable) begin
      w_stateNext        = S_IDLE;
      w_lastGrantNext    = GRANT_DEC;
      w_cntNext          = '0;
      w_coreReqNext      = 1'b0;
      w_coreSelRxNext    = 1'b0;
      w_coreRxPcmNext    = '0;
      w_coreRxAdpcmNext  = '0;
      w_encAdpcmNext     = '0;
      w_decPcmNext       = '0;
      w_encOutValidNext  = 1'b0;
      w_decOutValidNext  = 1'b0;
      w_errNext          = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_lastGrant   <= GRANT_DEC;
      r_cnt         <= '0;
      r_coreReq     <= 1'b0;
      r_coreSelRx   <= 1'b0;
      r_coreRxPcm   <= '0;
      r_coreRxAdpcm <= '0;
      r_encAdpcm    <= '0;
      r_decPcm      <= '0;
      r_encOutValid <= 1'b0;
      r_decOutValid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_lastGrant   <= w_lastGrantNext;
      r_cnt         <= w_cntNext;
      r_coreReq     <= w_coreReqNext;
      r_coreSelRx   <= w_coreSelRxNext;
      r_coreRxPcm   <= w_coreRxPcmNext;
      r_coreRxAdpcm <= w_coreRxAdpcmNext;
      r_encAdpcm    <= w_encAdpcmNext;
      r_decPcm      <= w_decPcmNext;
      r_encOutValid <= w_encOutValidNext;
      r_decOutValid <= w_decOutValidNext;
      r_err         <= w_errNext;
    end
  end

  assign o_enc_ready     = w_encReady;
  assign o_dec_ready     = w_decReady;
  assign o_enc_out_valid = r_encOutValid;
  assign o_dec_out_valid = r_decOutValid;
  assign o_enc_adpcm     = r_encAdpcm;
  assign o_dec_pcm       = r_decPcm;
  assign o_core_enable   = i_enable;
  assign o_core_req      = r_coreReq;
  assign o_core_sel_rx   = r_coreSelRx;
  assign o_core_rx_pcm   = r_coreRxPcm;
  assign o_core_rx_adpcm = r_coreRxAdpcm;
  assign o_busy          = (r_state != S_IDLE);
  assign o_err           = r_err;

endmodule
